// File: rtl/ysyx_22050518_pkg.sv
// Shared types for the EX issue controller: FSM encoding, EX/WB slot records
// and the default post-jump flush length.
package ysyx_22050518_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
    logic       mdu;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } wb_slot_t;

  localparam int DEF_FLUSH_CYCLES = 1;

endpackage

// File: rtl/ysyx_22050518_raw_cmp.sv
// Read-after-write match of one decode source against one in-flight slot;
// x0 never matches because it is never really written.
module ysyx_22050518_raw_cmp (
  input  logic       slot_valid,
  input  logic       slot_wen,
  input  logic [4:0] slot_rd,
  input  logic [4:0] src_addr,
  input  logic       src_ren,
  output logic       match
);

  assign match = slot_valid & slot_wen & src_ren &
                 (src_addr != 5'd0) & (slot_rd == src_addr);

endmodule

// File: rtl/ysyx_22050518_exu_issue_ctrl.sv
// Decode-to-EX issue/hazard controller: EX slot valid, forward selects, MDU wait
// and jump flush sequencing. Forwarding is enabled by YSYX_22050518_FWD_EN.
module ysyx_22050518_exu_issue_ctrl
  import ysyx_22050518_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_ren,
  input  logic       id_rs2_ren,
  input  logic [4:0] id_rd_addr,
  input  logic       id_rd_wen,
  input  logic       id_is_load,
  input  logic       id_is_mdu,
  input  logic       exu_ready,
  input  logic       jup,
  output logic       id_allowin,
  output logic       id_flush,
  output logic       idex_load,
  output logic       exu_en,
  output logic       rs1_sel,
  output logic       rs2_sel,
  output logic       mdu_busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

  issue_state_e     state_q, state_d;
  ex_slot_t         ex_q, ex_d;
  wb_slot_t         wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic m1_ex, m2_ex, m1_wb, m2_wb;
  logic load_use, hazard, fire;

  ysyx_22050518_raw_cmp u_cmp_rs1_ex (.slot_valid(ex_q.valid), .slot_wen(ex_q.wen), .slot_rd(ex_q.rd),
                                      .src_addr(id_rs1_addr), .src_ren(id_rs1_ren), .match(m1_ex));
  ysyx_22050518_raw_cmp u_cmp_rs2_ex (.slot_valid(ex_q.valid), .slot_wen(ex_q.wen), .slot_rd(ex_q.rd),
                                      .src_addr(id_rs2_addr), .src_ren(id_rs2_ren), .match(m2_ex));
  ysyx_22050518_raw_cmp u_cmp_rs1_wb (.slot_valid(wb_q.valid), .slot_wen(wb_q.wen), .slot_rd(wb_q.rd),
                                      .src_addr(id_rs1_addr), .src_ren(id_rs1_ren), .match(m1_wb));
  ysyx_22050518_raw_cmp u_cmp_rs2_wb (.slot_valid(wb_q.valid), .slot_wen(wb_q.wen), .slot_rd(wb_q.rd),
                                      .src_addr(id_rs2_addr), .src_ren(id_rs2_ren), .match(m2_wb));

  // Load data is never forwardable; without forwarding every RAW stalls too.
  assign load_use = ((m1_ex | m2_ex) & ex_q.load) | ((m1_wb | m2_wb) & wb_q.load);
`ifdef YSYX_22050518_FWD_EN
  assign hazard = load_use;
`else
  assign hazard = load_use | m1_ex | m2_ex | m1_wb | m2_wb;
`endif

  assign id_allowin = (state_q == RUN) & exu_ready & ~jup & ~hazard;
  assign fire       = id_valid & id_allowin;
  assign id_flush   = jup;
  assign idex_load  = exu_ready;
  assign exu_en     = ex_q.valid;
  assign mdu_busy   = (state_q == MDU_WAIT);

  always_comb begin
    ex_d = ex_q;
    wb_d = wb_q;
    if (exu_ready) begin
      wb_d.valid = ex_q.valid;
      wb_d.rd    = ex_q.rd;
      wb_d.wen   = ex_q.wen;
      wb_d.load  = ex_q.load;
      ex_d       = fire ? '{valid: 1'b1, rd: id_rd_addr, wen: id_rd_wen,
                           load: id_is_load, mdu: id_is_mdu}
                        : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (jup && (FLUSH_CYCLES > 0)) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end else if (ex_q.valid && ex_q.mdu && !exu_ready) begin
          state_d = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        if (exu_ready) begin
          if (jup && (FLUSH_CYCLES > 0)) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ex_q    <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef YSYX_22050518_FWD_EN
  logic rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;

  always_comb begin
    rs1_sel_d = rs1_sel_q;
    rs2_sel_d = rs2_sel_q;
    if (exu_ready) begin
      rs1_sel_d = fire & m1_ex;
      rs2_sel_d = fire & m2_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_sel_q <= 1'b0;
      rs2_sel_q <= 1'b0;
    end else begin
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
    end
  end

  assign rs1_sel = rs1_sel_q;
  assign rs2_sel = rs2_sel_q;
`else
  assign rs1_sel = 1'b0;
  assign rs2_sel = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050518_exu_issue_ctrl.sv
// Scoreboard bench: each directed vector pushes its expected output word,
// a negedge monitor pops and compares {allowin,flush,idex_load,exu_en,rs1_sel,rs2_sel,mdu_busy}.
module tb_ysyx_22050518_exu_issue_ctrl;

  logic       clk, rst_n, id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_ren, id_rs2_ren, id_rd_wen, id_is_load, id_is_mdu;
  logic       exu_ready, jup;
  logic       id_allowin, id_flush, idex_load, exu_en, rs1_sel, rs2_sel, mdu_busy;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  ysyx_22050518_exu_issue_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
    .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .exu_ready(exu_ready), .jup(jup),
    .id_allowin(id_allowin), .id_flush(id_flush), .idex_load(idex_load),
    .exu_en(exu_en), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [6:0] got;
      e   = exp_q.pop_front();
      got = {id_allowin, id_flush, idex_load, exu_en, rs1_sel, rs2_sel, mdu_busy};
      n_vec++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b (allowin,flush,idex_load,exu_en,rs1_sel,rs2_sel,mdu_busy)",
                 e.name, got, e.exp);
      end
    end
  end

  task automatic v(input string nm, input logic rst, input logic vld,
                   input logic [4:0] rs1, input logic r1en, input logic [4:0] rs2, input logic r2en,
                   input logic [4:0] rd, input logic wen, input logic ld, input logic mdu,
                   input logic rdy, input logic jp, input logic [6:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst; id_valid = vld;
    id_rs1_addr = rs1; id_rs1_ren = r1en; id_rs2_addr = rs2; id_rs2_ren = r2en;
    id_rd_addr = rd; id_rd_wen = wen; id_is_load = ld; id_is_mdu = mdu;
    exu_ready = rdy; jup = jp;
    x.name = nm;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic alu(input string nm, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [6:0] e);
    v(nm, 1'b1, 1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, e);
  endtask

  task automatic nop(input string nm, input logic [6:0] e);
    v(nm, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; id_rd_wen = 1'b0;
    id_is_load = 1'b0; id_is_mdu = 1'b0; exu_ready = 1'b1; jup = 1'b0;
    repeat (2) @(posedge clk);

    v("reset_state", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1010000);
    nop("idle", 7'b1010000);

    // back-to-back ALU dependency on rs1
    alu("a_add1", 5'd1, 5'd2, 5'd3, 7'b1010000);
`ifdef YSYX_22050518_FWD_EN
    alu("a_add2_issue", 5'd2, 5'd1, 5'd3, 7'b1011000);
    nop("a_rs1_sel",    7'b1011100);
    nop("a_drain",      7'b1010000);
`else
    alu("a_stall1", 5'd2, 5'd1, 5'd3, 7'b0011000);
    alu("a_stall2", 5'd2, 5'd1, 5'd3, 7'b0010000);
    alu("a_issue",  5'd2, 5'd1, 5'd3, 7'b1010000);
    nop("a_no_sel", 7'b1011000);
    nop("a_drain1", 7'b1010000);
    nop("a_drain2", 7'b1010000);
`endif

    // load-use: two bubbles, no forward
    v("b_ld", 1'b1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010000);
    alu("b_use_stall1", 5'd6, 5'd5, 5'd5, 7'b0011000);
    alu("b_use_stall2", 5'd6, 5'd5, 5'd5, 7'b0010000);
    alu("b_use_issue",  5'd6, 5'd5, 5'd5, 7'b1010000);
    nop("b_no_sel",     7'b1011000);
    nop("b_drain1",     7'b1010000);
    nop("b_drain2",     7'b1010000);

    // load already in wb slot: one bubble
    v("c_ld", 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010000);
    alu("c_indep", 5'd9, 5'd11, 5'd12, 7'b1011000);
    v("c_use_stall", 1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0011000);
    v("c_use_issue", 1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1010000);
    nop("c_no_sel", 7'b1011000);
    nop("c_drain1", 7'b1010000);
    nop("c_drain2", 7'b1010000);

    // x0 write then x0 read: no stall, no forward
    alu("d_wr_x0",   5'd0,  5'd13, 5'd14, 7'b1010000);
    alu("d_rd_x0",   5'd15, 5'd0,  5'd0,  7'b1011000);
    nop("d_no_sel",  7'b1011000);
    nop("d_drain1",  7'b1010000);
    nop("d_drain2",  7'b1010000);

    // dependency on rs2
    alu("e_add", 5'd20, 5'd22, 5'd23, 7'b1010000);
`ifdef YSYX_22050518_FWD_EN
    alu("e_issue_rs2", 5'd21, 5'd22, 5'd20, 7'b1011000);
    nop("e_rs2_sel",   7'b1011010);
    nop("e_drain",     7'b1010000);
`else
    alu("e_stall1", 5'd21, 5'd22, 5'd20, 7'b0011000);
    alu("e_stall2", 5'd21, 5'd22, 5'd20, 7'b0010000);
    alu("e_issue",  5'd21, 5'd22, 5'd20, 7'b1010000);
    nop("e_no_sel", 7'b1011000);
    nop("e_drain1", 7'b1010000);
    nop("e_drain2", 7'b1010000);
`endif

    // MUL with exu_ready low for 8 cycles
    v("m_mul", 1'b1, 1'b1, 5'd17, 1'b1, 5'd18, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1010000);
    v("m_wait_enter", 1'b1, 1'b1, 5'd24, 1'b1, 5'd25, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
    for (int i = 0; i < 7; i++)
      v("m_busy", 1'b1, 1'b1, 5'd24, 1'b1, 5'd25, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001);
    alu("m_ready_back", 5'd19, 5'd24, 5'd25, 7'b0011001);
    alu("m_issue",      5'd19, 5'd24, 5'd25, 7'b1010000);
    nop("m_exu_en",     7'b1011000);
    nop("m_drain1",     7'b1010000);
    nop("m_drain2",     7'b1010000);

    // taken jump with decode valid, two flush cycles
    alu("j_add", 5'd26, 5'd2, 5'd3, 7'b1010000);
    v("j_jup", 1'b1, 1'b1, 5'd28, 1'b1, 5'd29, 1'b1, 5'd27, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0111000);
    alu("j_flush1",  5'd27, 5'd28, 5'd29, 7'b0010000);
    alu("j_flush2",  5'd27, 5'd28, 5'd29, 7'b0010000);
    alu("j_resume",  5'd27, 5'd28, 5'd29, 7'b1010000);
    nop("j_exu_en",  7'b1011000);
    nop("j_drain1",  7'b1010000);
    nop("j_drain2",  7'b1010000);

    // reset in MDU_WAIT
    v("r_mul", 1'b1, 1'b1, 5'd17, 1'b1, 5'd18, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1010000);
    v("r_wait1", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
    v("r_wait2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001);
    v("r_rst",   1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001);
    nop("r_after_rst", 7'b1010000);
    nop("r_idle",      7'b1010000);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050518_exu_issue_ctrl.md
# ysyx_22050518_exu_issue_ctrl

Issue/hazard controller between the decode stage and `ysyx_22050518_exu_stage`. It owns the EX-slot valid bit (`exu_en`) and decides each cycle whether the decoded instruction issues, stalls or is killed. It generates the registered operand-forward selects (`rs1_sel`/`rs2_sel`) and sequences multi-cycle ALU-fusion operations and jump flushes.

## Interface
- `FLUSH_CYCLES`, 1: cycles after a taken jump during which `id_valid` is ignored (0 allowed).
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `id_valid`  in  1  decoded instruction present
- `id_rs1_addr`, `id_rs2_addr`  in  5  source registers
- `id_rs1_ren`, `id_rs2_ren`  in  1  source actually read
- `id_rd_addr`  in  5  destination
- `id_rd_wen`  in  1  writes rd
- `id_is_load`  in  1  load instruction
- `id_is_mdu`  in  1  multi-cycle fusion op (`alu_op[4:3]==2'b11`)
- `exu_ready`  in  1  `pipe3_allowin` from EX
- `jup`  in  1  taken jump/branch from EX
- `id_allowin`  out  1  decode instruction accepted this cycle
- `id_flush`  out  1  kill decode/fetch contents (equals `jup`)
- `idex_load`  out  1  ID/EX register load enable (equals `exu_ready`)
- `exu_en`  out  1  EX slot valid (registered)
- `rs1_sel`, `rs2_sel`  out  1  forward from `rd_second_stage` (registered)
- `mdu_busy`  out  1  state is MDU_WAIT

## Operation
- Tracking: `ex_slot` {valid, rd, wen, load, mdu} = instruction now in EX; `wb_slot` {valid, rd, wen, load} = instruction in the EX output register. On `exu_ready`, `wb_slot<=ex_slot`, `ex_slot<=` issued instruction or bubble.
- Match(a) = slot.valid & slot.wen & slot.rd==a & a!=0 & ren.
- Load-use hazard: match against `ex_slot` or `wb_slot` whose load=1 -> no issue.
- Issue fire = `id_valid & id_allowin`; `id_allowin = state==RUN & exu_ready & !jup & !hazard`.
- Forward selects loaded on `exu_ready`: `rs1_sel <= fire & Match_ex(id_rs1_addr)`, same for rs2; bubbles clear them.
- Register file is write-through; `wb_slot` hazards for non-loads need no action.
- FSM RUN/MDU_WAIT/FLUSH:
  - RUN -> FLUSH on `jup` (if `FLUSH_CYCLES>0`), -> MDU_WAIT when `ex_slot.mdu & !exu_ready`.
  - MDU_WAIT -> RUN when `exu_ready`; `jup` in that cycle goes to FLUSH.
  - FLUSH: down-counter loaded with `FLUSH_CYCLES-1`; -> RUN at 0; no issue.
- `jup` has priority over issue: decode instruction killed, bubble enters EX.

## Timing
- Reset: `exu_en=0`, `rs1_sel=rs2_sel=0`, `mdu_busy=0`, state RUN, both slots invalid, counter 0.
- Issue to `exu_en=1`: 1 cycle. Load-use stall: 2 bubbles (1 if load already in `wb_slot`).
- `exu_ready=0`: all slot and select registers hold; `exu_en` stays 1.
- `id_allowin`, `id_flush`, `idex_load` combinational; no input-to-output loop through `id_valid`.
- `jup` and hazard same cycle: flush wins, hazard irrelevant.
- Reset mid-MDU/FLUSH: immediate return to reset values next edge.

## Configuration
- `YSYX_22050518_FWD_EN` defined: forwarding as above.
- Undefined: `rs1_sel/rs2_sel` tied 0; any Match against `ex_slot` or `wb_slot` (load or not) is a hazard.

## Structure
- Package `ysyx_22050518_pkg`: FSM state encoding (RUN=0, MDU_WAIT=1, FLUSH=2), slot struct typedef, default `FLUSH_CYCLES`.
- Sub-module `ysyx_22050518_raw_cmp`: 5-bit match with x0 mask and ren/wen/valid qualification, instantiated four times.

## Test plan
- ADD x1 then ADD x2,x1,x3 back-to-back, FWD on -> both issue consecutively, `rs1_sel=1` with second's `exu_en`; FWD off -> 2 bubbles, `rs1_sel=0`.
- LD x5 then ADD x6,x5,x5 -> `id_allowin=0` 2 cycles, then issue, `rs1_sel=rs2_sel=0`.
- Write to x0 then read x0 -> no stall, no forward.
- MUL with `exu_ready` low 8 cycles -> `mdu_busy=1` 8 cycles, `exu_en` held 1, no issue, RUN when ready returns.
- `jup` with `id_valid=1`, `FLUSH_CYCLES=2` -> `id_flush=1`, next `exu_en=0`, `id_allowin=0` 2 cycles, then resumes.
- `rst_n=0` during MDU_WAIT -> next cycle all outputs at reset values, state RUN.
